// File: rtl/pic_inta_sequencer_pkg.sv
// Shared definitions for the PIC in-service sequencer: OCW2 command codes,
// sequencer states and the rotating-priority rank helper.
package pic_pkg;

  localparam int         NUM_IR       = 8;
  localparam logic [2:0] LOW_PRI_RST  = 3'd7;
  localparam logic [2:0] SPURIOUS_LVL = 3'd7;

  // OCW2 {R,SL,EOI} field
  typedef enum logic [2:0] {
    OCW2_ROT_AEOI_CLR = 3'b000,
    OCW2_NS_EOI       = 3'b001,
    OCW2_NOP          = 3'b010,
    OCW2_SP_EOI       = 3'b011,
    OCW2_ROT_AEOI_SET = 3'b100,
    OCW2_ROT_NS_EOI   = 3'b101,
    OCW2_SET_PRI      = 3'b110,
    OCW2_ROT_SP_EOI   = 3'b111
  } ocw2_cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_PEND = 2'd1,
    ACK1     = 2'd2
  } seq_state_e;

  // Rank 0 is the highest priority: the level just above the lowest one.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_rot_prio_enc.sv
// Rotating priority encoder: finds the highest-priority set bit of vec when
// level (lowest_pri+1) mod 8 ranks highest and lowest_pri ranks lowest.
module pic_rot_prio_enc (
  input  logic [7:0] vec,
  input  logic [2:0] lowest_pri,
  output logic       valid,
  output logic [2:0] level
);

  logic [7:0] rot_vec;
  logic [2:0] first_rank;

  // Rotate so bit 0 of rot_vec is the currently highest-priority level.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_vec[gi] = vec[lowest_pri + 3'(gi) + 3'd1];
    end
  endgenerate

  // Lowest set index of the rotated vector is the winning rank.
  always_comb begin
    first_rank = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_vec[k]) first_rank = 3'(k);
    end
  end

  assign valid = |rot_vec;
  assign level = lowest_pri + first_rank + 3'd1;

endmodule

// File: rtl/pic_inta_sequencer.sv
// PIC in-service control: ISR, rotating priority, INT generation, the
// two-pulse INTA handshake, OCW2 EOI/rotate commands and AEOI.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       aeoi_mode,
  input  logic [4:0] vector_base,
  input  logic       inta,
  input  logic       ocw2_wr,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  output logic       int_out,
  output logic [7:0] irr_clear,
  output logic [7:0] isr,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [2:0] lowest_pri
);

  seq_state_e state_reg;
  logic [7:0] isr_reg;
  logic [2:0] lowest_pri_reg;
  logic       rotate_aeoi_reg;
  logic [2:0] grant_reg;
  logic       spurious_reg;

  logic       req_valid, isr_valid;
  logic [2:0] req_lvl, isr_lvl;
  logic       qualify;
  logic       first_ack, second_ack, aeoi_act;
  logic [7:0] ocw2_clr, aeoi_clr, isr_set, isr_next;
  logic       ocw2_pri_wr;
  logic [2:0] ocw2_pri_val, lowest_pri_next;
  logic       rotate_aeoi_next;

  pic_rot_prio_enc u_req_enc (
    .vec        (irr & ~imr),
    .lowest_pri (lowest_pri_reg),
    .valid      (req_valid),
    .level      (req_lvl)
  );

  pic_rot_prio_enc u_isr_enc (
    .vec        (isr_reg),
    .lowest_pri (lowest_pri_reg),
    .valid      (isr_valid),
    .level      (isr_lvl)
  );

  // Fully nested: a request must strictly outrank the highest level in service.
  assign qualify = req_valid &&
                   (!isr_valid || (prio_rank(req_lvl, lowest_pri_reg) < prio_rank(isr_lvl, lowest_pri_reg)));

  assign first_ack  = (state_reg == INT_PEND) && inta;
  assign second_ack = (state_reg == ACK1) && inta;
  assign aeoi_act   = second_ack && aeoi_mode && !spurious_reg;

  // Decode OCW2 into ISR clears, a priority write and the rotate-in-AEOI flag.
  always_comb begin
    ocw2_clr         = 8'h00;
    ocw2_pri_wr      = 1'b0;
    ocw2_pri_val     = 3'd0;
    rotate_aeoi_next = rotate_aeoi_reg;
    if (ocw2_wr) begin
      case (ocw2_cmd_e'(ocw2_cmd))
        OCW2_NS_EOI: if (isr_valid) ocw2_clr = 8'b1 << isr_lvl;
        OCW2_SP_EOI: ocw2_clr = 8'b1 << ocw2_level;
        OCW2_ROT_NS_EOI: begin
          if (isr_valid) begin
            ocw2_clr     = 8'b1 << isr_lvl;
            ocw2_pri_wr  = 1'b1;
            ocw2_pri_val = isr_lvl;
          end
        end
        OCW2_ROT_SP_EOI: begin
          ocw2_clr     = 8'b1 << ocw2_level;
          ocw2_pri_wr  = 1'b1;
          ocw2_pri_val = ocw2_level;
        end
        OCW2_ROT_AEOI_SET: rotate_aeoi_next = 1'b1;
        OCW2_ROT_AEOI_CLR: rotate_aeoi_next = 1'b0;
        OCW2_SET_PRI: begin
          ocw2_pri_wr  = 1'b1;
          ocw2_pri_val = ocw2_level;
        end
        default: ;
      endcase
    end
  end

  // Merge ISR updates (a grant beats a same-bit clear) and pick the priority write (OCW2 beats AEOI rotate).
  always_comb begin
    aeoi_clr = aeoi_act ? (8'b1 << grant_reg) : 8'h00;
    isr_set  = (first_ack && qualify) ? (8'b1 << req_lvl) : 8'h00;
    isr_next = (isr_reg & ~(ocw2_clr | aeoi_clr)) | isr_set;
    if (ocw2_pri_wr)
      lowest_pri_next = ocw2_pri_val;
    else if (aeoi_act && rotate_aeoi_reg)
      lowest_pri_next = grant_reg;
    else
      lowest_pri_next = lowest_pri_reg;
  end

  // Handshake sequencer with registered outputs and state.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      state_reg       <= IDLE;
      isr_reg         <= 8'h00;
      lowest_pri_reg  <= LOW_PRI_RST;
      rotate_aeoi_reg <= 1'b0;
      grant_reg       <= 3'd0;
      spurious_reg    <= 1'b0;
      int_out         <= 1'b0;
      irr_clear       <= 8'h00;
      vector          <= 8'h00;
      vector_valid    <= 1'b0;
    end else begin
      isr_reg         <= isr_next;
      lowest_pri_reg  <= lowest_pri_next;
      rotate_aeoi_reg <= rotate_aeoi_next;
      irr_clear       <= 8'h00;
      vector_valid    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (qualify) begin
            state_reg <= INT_PEND;
            int_out   <= 1'b1;
          end
        end
        INT_PEND: begin
          if (inta) begin
            state_reg <= ACK1;
            if (qualify) begin
              grant_reg    <= req_lvl;
              spurious_reg <= 1'b0;
              irr_clear    <= 8'b1 << req_lvl;
            end else begin
              grant_reg    <= SPURIOUS_LVL;
              spurious_reg <= 1'b1;
            end
          end else if (!qualify) begin
            state_reg <= IDLE;
            int_out   <= 1'b0;
          end
        end
        ACK1: begin
          if (inta) begin
            state_reg    <= IDLE;
            int_out      <= 1'b0;
            vector       <= {vector_base, grant_reg};
            vector_valid <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          int_out   <= 1'b0;
        end
      endcase
    end
  end

  assign isr        = isr_reg;
  assign lowest_pri = lowest_pri_reg;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench: directed handshake/nesting/AEOI/spurious/command
// scenarios followed by randomized traffic, all compared every cycle against
// a behavioural model of the PIC in-service rules.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [7:0] irr = 8'h00;
  logic [7:0] imr = 8'h00;
  logic       aeoi_mode = 1'b0;
  logic [4:0] vector_base = 5'h00;
  logic       inta = 1'b0;
  logic       ocw2_wr = 1'b0;
  logic [2:0] ocw2_cmd = 3'd0;
  logic [2:0] ocw2_level = 3'd0;

  logic       int_out;
  logic [7:0] irr_clear;
  logic [7:0] isr;
  logic [7:0] vector;
  logic       vector_valid;
  logic [2:0] lowest_pri;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  pic_inta_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .irr          (irr),
    .imr          (imr),
    .aeoi_mode    (aeoi_mode),
    .vector_base  (vector_base),
    .inta         (inta),
    .ocw2_wr      (ocw2_wr),
    .ocw2_cmd     (ocw2_cmd),
    .ocw2_level   (ocw2_level),
    .int_out      (int_out),
    .irr_clear    (irr_clear),
    .isr          (isr),
    .vector       (vector),
    .vector_valid (vector_valid),
    .lowest_pri   (lowest_pri)
  );

  always #5 clk = ~clk;

  // Model state: phase 0 = nothing pending, 1 = INT raised, 2 = first INTA taken.
  typedef struct packed {
    logic [7:0] isr;
    logic [2:0] lp;
    logic       rot;
    logic [1:0] phase;
    logic [2:0] grant;
    logic       spur;
    logic       intv;
    logic [7:0] clr;
    logic [7:0] vec;
    logic       vv;
  } mstate_t;

  mstate_t m;

  // 0 = highest priority, 7 = lowest.
  function automatic int rank_of(input int lvl, input int lp);
    return (lvl - lp + 7) % 8;
  endfunction

  // Level of the best-ranked set bit, or -1 when none.
  function automatic int top_level(input logic [7:0] v, input int lp);
    int best = -1;
    for (int l = 0; l < 8; l++)
      if (v[l] && (best < 0 || rank_of(l, lp) < rank_of(best, lp))) best = l;
    return best;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    int req, cur;
    logic qual;
    logic [7:0] clr_m, set_m;
    n = s;
    n.clr = 8'h00;
    n.vv = 1'b0;
    if (reset || init) begin
      n = '0;
      n.lp = 3'd7;
      return n;
    end
    req = top_level(irr & ~imr, int'(s.lp));
    cur = top_level(s.isr, int'(s.lp));
    qual = (req >= 0) && (cur < 0 || rank_of(req, int'(s.lp)) < rank_of(cur, int'(s.lp)));
    clr_m = 8'h00;
    set_m = 8'h00;
    case (s.phase)
      2'd0: if (qual) begin n.phase = 2'd1; n.intv = 1'b1; end
      2'd1: begin
        if (inta) begin
          n.phase = 2'd2;
          if (qual) begin
            n.grant = 3'(req);
            n.spur = 1'b0;
            set_m[req] = 1'b1;
          end else begin
            n.grant = 3'd7;
            n.spur = 1'b1;
          end
        end else if (!qual) begin
          n.phase = 2'd0;
          n.intv = 1'b0;
        end
      end
      2'd2: begin
        if (inta) begin
          n.phase = 2'd0;
          n.intv = 1'b0;
          n.vv = 1'b1;
          n.vec = {vector_base, s.grant};
          if (aeoi_mode && !s.spur) begin
            clr_m[s.grant] = 1'b1;
            if (s.rot) n.lp = s.grant;
          end
        end
      end
      default: ;
    endcase
    if (ocw2_wr) begin
      case (ocw2_cmd)
        3'b001: if (cur >= 0) clr_m[cur] = 1'b1;
        3'b011: clr_m[ocw2_level] = 1'b1;
        3'b101: if (cur >= 0) begin clr_m[cur] = 1'b1; n.lp = 3'(cur); end
        3'b111: begin clr_m[ocw2_level] = 1'b1; n.lp = ocw2_level; end
        3'b100: n.rot = 1'b1;
        3'b000: n.rot = 1'b0;
        3'b110: n.lp = ocw2_level;
        default: ;
      endcase
    end
    n.isr = (s.isr & ~clr_m) | set_m;
    n.clr = set_m;
    return n;
  endfunction

  // Advance the model on every rising edge.
  always @(posedge clk) m <= model_next(m);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_int_out", {7'd0, int_out}, {7'd0, m.intv});
    chk("m_irr_clear", irr_clear, m.clr);
    chk("m_isr", isr, m.isr);
    chk("m_vector", vector, m.vec);
    chk("m_vector_valid", {7'd0, vector_valid}, {7'd0, m.vv});
    chk("m_lowest_pri", {5'd0, lowest_pri}, {5'd0, m.lp});
  endtask

  // One clock; outputs are compared on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_model();
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic ocw2(input logic [2:0] c, input logic [2:0] l);
    ocw2_wr = 1'b1;
    ocw2_cmd = c;
    ocw2_level = l;
    tick();
    ocw2_wr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_int_out", {7'd0, int_out}, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_lowest_pri", {5'd0, lowest_pri}, 8'h07);
    chk("rst_vector", vector, 8'h00);

    // Basic handshake
    vector_base = 5'h08;
    irr = 8'h04;
    tick();
    chk("basic_int", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("basic_irr_clear", irr_clear, 8'h04);
    chk("basic_isr", isr, 8'h04);
    irr = 8'h00;
    tick();
    pulse_inta();
    chk("basic_vector", vector, 8'h42);
    chk("basic_vv", {7'd0, vector_valid}, 8'h01);
    chk("basic_int_drop", {7'd0, int_out}, 8'h00);
    tick();
    ocw2(3'b001, 3'd0);
    chk("basic_eoi_isr", isr, 8'h00);

    // Nesting
    irr = 8'h04;
    tick();
    pulse_inta();
    irr = 8'h00;
    tick();
    pulse_inta();
    irr = 8'h08;
    tick();
    tick();
    chk("nest_no_int", {7'd0, int_out}, 8'h00);
    irr = 8'h09;
    tick();
    chk("nest_int", {7'd0, int_out}, 8'h01);
    pulse_inta();
    chk("nest_irr_clear", irr_clear, 8'h01);
    irr = 8'h08;
    tick();
    pulse_inta();
    chk("nest_vec_low", vector & 8'h07, 8'h00);
    chk("nest_isr", isr, 8'h05);
    irr = 8'h00;
    ocw2(3'b001, 3'd0);
    chk("nest_eoi1", isr, 8'h04);
    ocw2(3'b001, 3'd0);
    chk("nest_eoi2", isr, 8'h00);

    // AEOI with rotate
    aeoi_mode = 1'b1;
    ocw2(3'b100, 3'd0);
    irr = 8'h20;
    tick();
    pulse_inta();
    irr = 8'h00;
    tick();
    pulse_inta();
    chk("aeoi_isr", isr, 8'h00);
    chk("aeoi_lp", {5'd0, lowest_pri}, 8'h05);
    chk("aeoi_vec5", vector, 8'h45);
    irr = 8'h41;
    tick();
    pulse_inta();
    chk("aeoi_clr_ir6", irr_clear, 8'h40);
    irr = 8'h01;
    tick();
    pulse_inta();
    chk("aeoi_vec6", vector, 8'h46);
    tick();
    pulse_inta();
    irr = 8'h00;
    tick();
    pulse_inta();
    chk("aeoi_vec0", vector, 8'h40);
    aeoi_mode = 1'b0;
    ocw2(3'b000, 3'd0);
    ocw2(3'b110, 3'd7);
    chk("setpri7", {5'd0, lowest_pri}, 8'h07);

    // Spurious: request withdrawn before INTA
    irr = 8'h02;
    tick();
    chk("spur_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    tick();
    chk("spur_int_drop", {7'd0, int_out}, 8'h00);
    pulse_inta();
    chk("spur_no_vv1", {7'd0, vector_valid}, 8'h00);
    tick();
    pulse_inta();
    chk("spur_no_vv2", {7'd0, vector_valid}, 8'h00);

    // Spurious: masked on the first INTA
    irr = 8'h02;
    tick();
    imr = 8'h02;
    pulse_inta();
    chk("spurm_clr", irr_clear, 8'h00);
    chk("spurm_isr", isr, 8'h00);
    tick();
    pulse_inta();
    chk("spurm_vector", vector, 8'h47);
    chk("spurm_vv", {7'd0, vector_valid}, 8'h01);
    imr = 8'h00;
    irr = 8'h00;
    tick();

    // Commands
    ocw2(3'b110, 3'd3);
    chk("cmd_lp3", {5'd0, lowest_pri}, 8'h03);
    irr = 8'h11;
    tick();
    pulse_inta();
    chk("cmd_clr_ir4", irr_clear, 8'h10);
    irr = 8'h01;
    tick();
    pulse_inta();
    chk("cmd_vec4", vector, 8'h44);
    chk("cmd_isr4", isr, 8'h10);
    tick();
    chk("cmd_no_int", {7'd0, int_out}, 8'h00);
    ocw2(3'b011, 3'd4);
    chk("cmd_sp_eoi", isr, 8'h00);
    tick();
    pulse_inta();
    chk("cmd_isr0", isr, 8'h01);
    irr = 8'h00;
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_isr", isr, 8'h00);
    chk("init_lp", {5'd0, lowest_pri}, 8'h07);
    chk("init_int", {7'd0, int_out}, 8'h00);
    pulse_inta();
    chk("init_no_vv", {7'd0, vector_valid}, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) irr = 8'($urandom);
      if ($urandom_range(0, 15) == 0) imr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 63) == 0) vector_base = 5'($urandom);
      if ($urandom_range(0, 99) == 0) aeoi_mode = ~aeoi_mode;
      inta = ($urandom_range(0, 3) == 0);
      ocw2_wr = ($urandom_range(0, 9) == 0);
      ocw2_cmd = 3'($urandom);
      ocw2_level = 3'($urandom);
      init = ($urandom_range(0, 199) == 0);
      tick();
    end
    inta = 1'b0;
    ocw2_wr = 1'b0;
    init = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
